// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and counter sizing for serial_subtractor.
// Rev 1.0
`default_nettype none

package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The bit counter must be able to represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor, d = a - b - bin.
// Rev 1.0
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock.
// Optional overflow output: define SERIAL_SUB_OVERFLOW_EN.  Rev 1.0
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] myDiff,
    output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int               C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [WIDTH-1:0]   r_sh;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sh_next;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last    = (r_cnt == C_LAST);
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sh_next = WIDTH'({w_d, r_sh} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Published result is only updated on the final shift, so it holds during SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_sh   <= '0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= operandA;
            r_b   <= operandB;
            r_br  <= Bin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_bout;
            r_sh  <= w_sh_next;
            r_cnt <= r_cnt + C_ONE;
            if (w_last) begin
                r_diff <= w_sh_next;
                r_bout <= w_bout;
            end
        end
    end

    assign myDiff = r_diff;
    assign Bout   = r_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= operandA[WIDTH-1];
            r_bmsb <= operandB[WIDTH-1];
        end else if ((r_state == SHIFT) && w_last) begin
            // w_d is the result MSB on the final shift.
            r_ovf <= (r_amsb != r_bmsb) && (w_d != r_amsb);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 operandA  input  WIDTH  minuend; sampled only when start is accepted.
REQ-006 operandB  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-007 Bin  input  1  borrow-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while the block is shifting.
REQ-009 done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 myDiff  output  WIDTH  result, operandA - operandB - Bin, modulo 2^WIDTH.
REQ-011 Bout  output  1  final borrow-out; high when operandA < operandB + Bin (unsigned).

Function
REQ-012 Shall be a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE: start=1 is accepted; on that edge operandA, operandB and Bin are latched, the bit counter clears, and the FSM moves to SHIFT.
REQ-014 SHIFT: each cycle the LSBs of the latched A and B and the borrow FF feed one full subtractor.
- diff = a^b^br.
- br_next = (~a&b) | (~(a^b)&br).
- A and B shift right one bit; diff enters the result register MSB-first-shift (right shift); the counter increments.
REQ-015 After exactly WIDTH SHIFT cycles, the FSM moves to DONE.
- myDiff holds the full result and Bout equals the borrow FF.
- Latency: done high in cycle WIDTH+1 after the start edge.
REQ-016 DONE lasts one cycle with done=1, busy=0, then returns to IDLE, except as given in REQ-017.
REQ-017 start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and goes directly to SHIFT.
REQ-018 start asserted during SHIFT shall be ignored; the latched operands are not disturbed.
REQ-019 busy=1 exactly in SHIFT; done=1 exactly in DONE.
REQ-020 myDiff and Bout shall hold the last completed result until the next DONE.
- They are undefined-free (registered) during SHIFT: they keep their previous value.
- Internal shifting uses a separate register.
REQ-021 Operands of all zeros or all ones are handled with no special casing.
- Example: 0-0-1 gives all ones with Bout=1.

Reset
REQ-022 rst=1 forces IDLE immediately, including in the middle of an operation, which is aborted.
REQ-023 All outputs shall be 0 during and after reset: busy, done, myDiff, Bout and, if present, ovf.
REQ-024 The first start after rst deasserts shall be accepted normally.

Configuration
REQ-025 Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), registered with myDiff, held like it (REQ-020), and reset to 0.
- ovf = two's-complement overflow, i.e. (A_msb != B_msb) && (myDiff_msb != A_msb), using the latched operand MSBs.
- Undefined: the port is absent and no overflow logic is built.

Structure
REQ-026 Package serial_sub_pkg shall hold the FSM state enum (IDLE, SHIFT, DONE) and a function giving the counter width, $clog2(WIDTH+1).
REQ-027 Sub-module full_subtractor shall contain the one-bit combinational subtractor: inputs a, b, bin; outputs d, bout.
- Instantiated once; all sequencing stays in serial_subtractor.

Verification
REQ-028 WIDTH=4: A=9, B=3, Bin=0 -> myDiff=6, Bout=0, done high in the 5th cycle after the start edge.
REQ-029 A=3, B=9, Bin=0 -> myDiff=4'hA, Bout=1.
REQ-030 A=0, B=0, Bin=1 -> myDiff=4'hF, Bout=1.
REQ-031 Start A=5, B=2, then assert start with A=1, B=1 two cycles later -> second request ignored; result 3.
- Then start in the DONE cycle with A=7, B=7 -> 0, done exactly WIDTH+1 cycles later.
REQ-032 rst pulsed during the 2nd SHIFT cycle -> busy=0, myDiff=0, Bout=0 at once; the next start with A=15, B=1 -> 14.
REQ-033 With SERIAL_SUB_OVERFLOW_EN: A=8, B=1 -> myDiff=7, ovf=1; A=6, B=2 -> myDiff=4, ovf=0.
